// File: rtl/chacha_pkg.sv
// ChaCha shared definitions: the "expand 32-byte k" constants, the 16-word
// state type, the block-core FSM encoding and the quarter-round index tables
// for column and diagonal rounds.
package chacha_pkg;

  localparam logic [31:0] CHACHA_CONST [0:3] = '{
    32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574
  };

  // Word i of the state lives at bits [32i+31:32i], so the packed value
  // maps one-to-one onto the 512-bit keystream bus.
  typedef logic [15:0][31:0] chacha_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } chacha_fsm_t;

  // [quarter-round instance][a,b,c,d] -> state word index
  localparam logic [3:0] COL_IDX [0:3][0:3] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };

  localparam logic [3:0] DIAG_IDX [0:3][0:3] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  // Initial state: constants, key words 4..11, counter word 12, nonce 13..15.
  function automatic chacha_state_t init_state(input logic [255:0] key,
                                               input logic [95:0]  nonce,
                                               input logic [31:0]  counter);
    chacha_state_t s;
    for (int i = 0; i < 4; i++) s[i] = CHACHA_CONST[i];
    for (int i = 0; i < 8; i++) s[4 + i] = key[32*i +: 32];
    s[12] = counter;
    for (int i = 0; i < 3; i++) s[13 + i] = nonce[32*i +: 32];
    return s;
  endfunction

endpackage

// File: rtl/chacha_qr.sv
// ChaCha quarter round, purely combinational.
// Ports:
//   a, b, c, d                  in  32  input words
//   a_new, b_new, c_new, d_new  out 32  quarter-round result
// Rotates are fixed rewiring; adds are 32-bit with the carry dropped.
module chacha_qr (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] a_new,
  output logic [31:0] b_new,
  output logic [31:0] c_new,
  output logic [31:0] d_new
);

  logic [31:0] a1, b1, c1, d1;
  logic [31:0] a2, b2, c2, d2;
  logic [31:0] dx1, bx1, dx2, bx2;

  always_comb begin
    a1    = a + b;
    dx1   = d ^ a1;
    d1    = {dx1[15:0], dx1[31:16]};   // <<< 16
    c1    = c + d1;
    bx1   = b ^ c1;
    b1    = {bx1[19:0], bx1[31:20]};   // <<< 12
    a2    = a1 + b1;
    dx2   = d1 ^ a2;
    d2    = {dx2[23:0], dx2[31:24]};   // <<< 8
    c2    = c1 + d2;
    bx2   = b1 ^ c2;
    b2    = {bx2[24:0], bx2[31:25]};   // <<< 7
    a_new = a2;
    b_new = b2;
    c_new = c2;
    d_new = d2;
  end

endmodule

// File: rtl/chacha_block_core.sv
// Iterative ChaCha block function: four quarter-round instances evaluate one
// full column or diagonal round per clock. Produces one 512-bit keystream
// block per request, optionally re-running with counter+1 after each output
// handshake.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/ready   request handshake (key, nonce, counter, auto_inc)
//   key[255:0]       key words 0..7 (word 0 in the low bits)
//   nonce[95:0]      nonce words 0..2
//   counter[31:0]    initial block counter
//   auto_inc         latched at accept: keep producing counter+1 blocks
//   out_valid/ready  keystream handshake
//   keystream[511:0] final state (work + init), word i at [32i+31:32i]
//   out_counter      block counter of the presented keystream
//   ctr_wrap         out_counter is all ones; the next auto block wraps to 0
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. out_valid and in_ready are registers; neither depends
// combinationally on the other side's signal.
module chacha_block_core
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20,
  parameter int CNT_W  = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter,
  input  logic         auto_inc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] keystream,
  output logic [31:0]  out_counter,
  output logic         ctr_wrap
);

  if ((ROUNDS % 2) != 0 || ROUNDS < 2) begin : g_bad_rounds
    $error("chacha_block_core: ROUNDS must be a positive even number");
  end
  if ((2 ** CNT_W) <= ROUNDS) begin : g_bad_cnt_w
    $error("chacha_block_core: CNT_W too narrow for ROUNDS");
  end

  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  chacha_fsm_t      state;
  logic [CNT_W-1:0] round_cnt;
  logic             auto_inc_q;
  chacha_state_t    init_q;
  chacha_state_t    work;
  chacha_state_t    work_rnd;
  chacha_state_t    ks_sum;
  chacha_state_t    next_init;

  logic [3:0]  sel [4][4];
  logic [31:0] qa [4], qb [4], qc [4], qd [4];
  logic [31:0] ra [4], rb [4], rc [4], rd [4];

  // Operand mux: even round_cnt selects the column pattern, odd the diagonal.
  always_comb begin
    for (int q = 0; q < 4; q++) begin
      for (int k = 0; k < 4; k++) begin
        sel[q][k] = round_cnt[0] ? DIAG_IDX[q][k] : COL_IDX[q][k];
      end
      qa[q] = work[sel[q][0]];
      qb[q] = work[sel[q][1]];
      qc[q] = work[sel[q][2]];
      qd[q] = work[sel[q][3]];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_qr
    chacha_qr u_qr (
      .a     (qa[g]),
      .b     (qb[g]),
      .c     (qc[g]),
      .d     (qd[g]),
      .a_new (ra[g]),
      .b_new (rb[g]),
      .c_new (rc[g]),
      .d_new (rd[g])
    );
  end

  // The four instances touch disjoint words, so write-back order is irrelevant.
  always_comb begin
    work_rnd = work;
    for (int q = 0; q < 4; q++) begin
      work_rnd[sel[q][0]] = ra[q];
      work_rnd[sel[q][1]] = rb[q];
      work_rnd[sel[q][2]] = rc[q];
      work_rnd[sel[q][3]] = rd[q];
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) ks_sum[i] = work[i] + init_q[i];
  end

  // Next block of an auto_inc run: same key/nonce, counter + 1 (wraps).
  always_comb begin
    next_init     = init_q;
    next_init[12] = init_q[12] + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      keystream   <= '0;
      out_counter <= '0;
      ctr_wrap    <= 1'b0;
      round_cnt   <= '0;
      auto_inc_q  <= 1'b0;
      init_q      <= '0;
      work        <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            init_q     <= init_state(key, nonce, counter);
            work       <= init_state(key, nonce, counter);
            round_cnt  <= '0;
            auto_inc_q <= auto_inc;
            in_ready   <= 1'b0;
            state      <= ROUND;
          end
        end
        ROUND: begin
          work      <= work_rnd;
          round_cnt <= round_cnt + 1'b1;
          if (round_cnt == LAST_RND) state <= FINAL;
        end
        FINAL: begin
          keystream   <= ks_sum;
          out_counter <= init_q[12];
          ctr_wrap    <= (init_q[12] == 32'hFFFF_FFFF);
          out_valid   <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (auto_inc_q) begin
              init_q    <= next_init;
              work      <= next_init;
              round_cnt <= '0;
              state     <= ROUND;
            end else begin
              in_ready <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_block_core.sv
// Directed bench for chacha_block_core (ROUNDS=20), plus ROUNDS=8/12 builds
// checked against a reference block function, and the quarter-round unit.
module tb_chacha_block_core;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- main DUT (ROUNDS=20) ----------------
  logic         in_valid, in_ready, auto_inc, out_valid, out_ready, ctr_wrap;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  counter, out_counter;
  logic [511:0] keystream;

  chacha_block_core #(.ROUNDS(20), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .nonce(nonce), .counter(counter), .auto_inc(auto_inc),
    .out_valid(out_valid), .out_ready(out_ready),
    .keystream(keystream), .out_counter(out_counter), .ctr_wrap(ctr_wrap)
  );

  // ---------------- reduced-round builds: [0]=8, [1]=12 ----------------
  logic         iv_s [2];
  logic         ir_s [2];
  logic         ov_s [2];
  logic         or_s [2];
  logic [511:0] ks_s [2];
  logic [31:0]  oc_s [2];
  logic         cw_s [2];

  chacha_block_core #(.ROUNDS(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv_s[0]), .in_ready(ir_s[0]),
    .key(key), .nonce(nonce), .counter(counter), .auto_inc(1'b0),
    .out_valid(ov_s[0]), .out_ready(or_s[0]),
    .keystream(ks_s[0]), .out_counter(oc_s[0]), .ctr_wrap(cw_s[0])
  );

  chacha_block_core #(.ROUNDS(12), .CNT_W(4)) dut12 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv_s[1]), .in_ready(ir_s[1]),
    .key(key), .nonce(nonce), .counter(counter), .auto_inc(1'b0),
    .out_valid(ov_s[1]), .out_ready(or_s[1]),
    .keystream(ks_s[1]), .out_counter(oc_s[1]), .ctr_wrap(cw_s[1])
  );

  // ---------------- quarter-round unit ----------------
  logic [31:0] qa, qb, qc, qd, ra, rb, rc, rd;

  chacha_qr u_qr (
    .a(qa), .b(qb), .c(qc), .d(qd),
    .a_new(ra), .b_new(rb), .c_new(rc), .d_new(rd)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qrf(input logic [31:0] a0, b0, c0, d0);
    logic [31:0] a, b, c, d;
    a = a0; b = b0; c = c0; d = d0;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                             input logic [31:0] c, input int rounds);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4 + i] = k[32*i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13 + i] = n[32*i +: 32];
    x = s;
    for (int i = 0; i < rounds / 2; i++) begin
      {x[0], x[4], x[8],  x[12]} = qrf(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qrf(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qrf(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qrf(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qrf(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qrf(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qrf(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qrf(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick(1);
      lat++;
    end
  endtask

  task automatic request(input logic [31:0] ctr, input logic ai, output int lat);
    int guard;
    guard    = 0;
    counter  = ctr;
    auto_inc = ai;
    while (!in_ready && guard < 50) begin
      tick(1);
      guard++;
    end
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    wait_out(lat);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  localparam logic [255:0] RFC_KEY =
    256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [95:0]  RFC_NONCE = 96'h00000000_4a000000_09000000;

  initial begin
    int           lat;
    int           guard;
    logic [31:0]  exp_c;
    logic [31:0]  ctr;
    logic [511:0] exp_ks;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    auto_inc  = 1'b0;
    key       = '0;
    nonce     = '0;
    counter   = '0;
    iv_s      = '{1'b0, 1'b0};
    or_s      = '{1'b0, 1'b0};
    qa = '0; qb = '0; qc = '0; qd = '0;

    // Reset values while rst_n is held low
    #12;
    check("rst_in_ready",    512'(in_ready),    512'(0));
    check("rst_out_valid",   512'(out_valid),   512'(0));
    check("rst_keystream",   keystream,         512'(0));
    check("rst_out_counter", 512'(out_counter), 512'(0));
    check("rst_ctr_wrap",    512'(ctr_wrap),    512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_in_ready",  512'(in_ready),  512'(1));
    check("post_rst_out_valid", 512'(out_valid), 512'(0));

    // Quarter-round unit vector
    qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
    #1;
    check("qr_a", 512'(ra), 512'(32'hea2a92f4));
    check("qr_b", 512'(rb), 512'(32'hcb1cf8ce));
    check("qr_c", 512'(rc), 512'(32'h4581472e));
    check("qr_d", 512'(rd), 512'(32'h5881c4bb));

    // Reference block, counter = 1
    key   = RFC_KEY;
    nonce = RFC_NONCE;
    request(32'd1, 1'b0, lat);
    check("rfc_latency",   512'(lat),             512'(21));
    check("rfc_w0",        512'(keystream[31:0]),    512'(32'he4e7f110));
    check("rfc_w1",        512'(keystream[63:32]),   512'(32'h15593bd1));
    check("rfc_w2",        512'(keystream[95:64]),   512'(32'h1fdd0f50));
    check("rfc_w3",        512'(keystream[127:96]),  512'(32'hc47120a3));
    check("rfc_w15",       512'(keystream[511:480]), 512'(32'h4e3c50a2));
    check("rfc_out_ctr",   512'(out_counter),     512'(1));
    check("rfc_ctr_wrap",  512'(ctr_wrap),        512'(0));
    check("rfc_in_ready",  512'(in_ready),        512'(0));
    exp_ks = ref_block(RFC_KEY, RFC_NONCE, 32'd1, 20);
    check("rfc_full",      keystream,             exp_ks);

    // Backpressure: 10 stalled cycles with a stray in_valid pulse
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      counter  = 32'h12345678;
      tick(1);
      check("bp_keystream", keystream,         exp_ks);
      check("bp_in_ready",  512'(in_ready),    512'(0));
      check("bp_out_valid", 512'(out_valid),   512'(1));
      check("bp_out_ctr",   512'(out_counter), 512'(1));
    end
    in_valid = 1'b0;
    handshake();
    check("bp_drop_out_valid", 512'(out_valid), 512'(0));
    check("bp_idle_in_ready",  512'(in_ready),  512'(1));
    tick(25);
    check("bp_pulse_ignored",  512'(out_valid), 512'(0));

    // auto_inc across the counter wrap
    exp_q.push_back(32'hFFFF_FFFE);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_0000);
    request(32'hFFFF_FFFE, 1'b1, lat);
    check("wrap_lat0", 512'(lat), 512'(21));
    for (int b = 0; b < 3; b++) begin
      if (b > 0) begin
        wait_out(lat);
        check("wrap_lat", 512'(lat), 512'(21));
      end
      exp_c = exp_q.pop_front();
      check("wrap_out_ctr",  512'(out_counter), 512'(exp_c));
      check("wrap_ctr_wrap", 512'(ctr_wrap),    512'(exp_c == 32'hFFFF_FFFF));
      check("wrap_ks",       keystream,         ref_block(RFC_KEY, RFC_NONCE, exp_c, 20));
      handshake();
      check("wrap_drop",     512'(out_valid),   512'(0));
    end

    // The fourth auto block is now mid-ROUND: reset discards it
    tick(5);
    check("busy_in_ready", 512'(in_ready), 512'(0));
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 512'(out_valid), 512'(0));
    check("mid_rst_in_ready",  512'(in_ready),  512'(0));
    check("mid_rst_keystream", keystream,       512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("mid_rst_release_ready", 512'(in_ready), 512'(1));
    request(32'd1, 1'b0, lat);
    check("rerun_latency", 512'(lat), 512'(21));
    check("rerun_w0",      512'(keystream[31:0]), 512'(32'he4e7f110));
    check("rerun_full",    keystream, exp_ks);
    handshake();
    check("rerun_idle", 512'(in_ready), 512'(1));

    // ROUNDS=8 and ROUNDS=12 builds on random key/nonce/counter
    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 6; v++) begin
        for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom;
        for (int i = 0; i < 3; i++) nonce[32*i +: 32] = $urandom;
        ctr     = $urandom;
        counter = ctr;
        guard   = 0;
        while (!ir_s[s] && guard < 50) begin
          tick(1);
          guard++;
        end
        iv_s[s] = 1'b1;
        tick(1);
        iv_s[s] = 1'b0;
        lat = 0;
        while (!ov_s[s] && lat < 200) begin
          tick(1);
          lat++;
        end
        check("small_latency", 512'(lat),     512'((s == 0 ? 8 : 12) + 1));
        check("small_ks",      ks_s[s],       ref_block(key, nonce, ctr, (s == 0 ? 8 : 12)));
        check("small_out_ctr", 512'(oc_s[s]), 512'(ctr));
        or_s[s] = 1'b1;
        tick(1);
        or_s[s] = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
